// File: rtl/ifd_pkg.sv
// Shared definitions for the instruction fetch/decode stage: field map, special
// function codes, FSM state encoding and the word-to-fields decode helper.
package ifd_pkg;

   localparam int INSTR_W  = 24;

   localparam int FUNC_LSB = 20;
   localparam int RD_LSB   = 16;
   localparam int R1_LSB   = 12;
   localparam int R2_LSB   = 8;
   localparam int ADDR_LSB = 0;
   localparam int FUNC_W   = 4;
   localparam int REG_W    = 4;
   localparam int ADDR_W   = 8;

   localparam logic [FUNC_W-1:0] FUNC_HALT = 4'd15;
   localparam logic [FUNC_W-1:0] FUNC_JMP  = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  r1;
      logic [REG_W-1:0]  r2;
      logic [ADDR_W-1:0] addr;
   } instr_t;

   function automatic instr_t decode(input logic [INSTR_W-1:0] w);
      instr_t f;
      f.func = w[FUNC_LSB +: FUNC_W];
      f.rd   = w[RD_LSB   +: REG_W];
      f.r1   = w[R1_LSB   +: REG_W];
      f.r2   = w[R2_LSB   +: REG_W];
      f.addr = w[ADDR_LSB +: ADDR_W];
      return f;
   endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Control, imem write port and decoded-instruction outputs of the fetch/decode
// stage. The slave side is the stage itself, the master side drives it.
interface instr_fetch_decode_if #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) ();
   import ifd_pkg::*;

   logic               start;
   logic               stall;
   logic               imem_we;
   logic [PC_W-1:0]    imem_waddr;
   logic [INSTR_W-1:0] imem_wdata;

   logic [REG_W-1:0]   r1;
   logic [REG_W-1:0]   r2;
   logic [REG_W-1:0]   rd;
   logic [FUNC_W-1:0]  func;
   logic [ADDR_W-1:0]  addr;
   logic               valid;
   logic [PC_W-1:0]    pc;
   logic               halted;
   logic [CNT_W-1:0]   issued;

   modport slave (
      input  start, stall, imem_we, imem_waddr, imem_wdata,
      output r1, r2, rd, func, addr, valid, pc, halted, issued
   );

   modport master (
      output start, stall, imem_we, imem_waddr, imem_wdata,
      input  r1, r2, rd, func, addr, valid, pc, halted, issued
   );

endinterface

// File: rtl/instr_fetch_decode.sv
// Instruction memory, program counter and registered decode for the execute pipeline.
// Build option: define BRANCH_EN to treat func=14 as an unconditional jump to addr.
//
// state | meaning
// IDLE  | after reset; imem writable, waiting for start
// RUN   | fetching one word per unstalled clk1 edge; imem write-protected
// HALT  | HALT word reached; imem writable, start restarts from pc 0
module instr_fetch_decode
   import ifd_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input logic             clk1,
   input logic             rst,
   instr_fetch_decode_if.slave bus
);

   localparam int DEPTH = 2**PC_W;

   logic [INSTR_W-1:0] imem [DEPTH];

   state_e           state_q;
   logic [PC_W-1:0]  pc_q;
   instr_t           fields_q;
   logic             valid_q;
   logic             halted_q;
   logic [CNT_W-1:0] issued_q;

   instr_t           fetch_w;
   logic [PC_W-1:0]  pc_d;
   logic [CNT_W-1:0] issued_d;

   // Write-protect the program while it is running; contents are never reset.
   always_ff @(posedge clk1) begin
      if (bus.imem_we && (state_q != ST_RUN))
         imem[bus.imem_waddr] <= bus.imem_wdata;
   end

   assign fetch_w  = decode(imem[pc_q]);
   assign pc_d     = pc_q + PC_W'(1);
   assign issued_d = (issued_q == {CNT_W{1'b1}}) ? issued_q : issued_q + CNT_W'(1);

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= '0;
         fields_q <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         issued_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               if (bus.start) begin
                  state_q <= ST_RUN;
                  pc_q    <= '0;
               end
            end
            ST_RUN: begin
               // A stalled HALT word stays unconsumed until the stall drops.
               if (!bus.stall) begin
                  if (fetch_w.func == FUNC_HALT) begin
                     valid_q  <= 1'b0;
                     halted_q <= 1'b1;
                     state_q  <= ST_HALT;
`ifdef BRANCH_EN
                  end else if (fetch_w.func == FUNC_JMP) begin
                     valid_q <= 1'b0;
                     pc_q    <= PC_W'(fetch_w.addr);
`endif
                  end else begin
                     fields_q <= fetch_w;
                     valid_q  <= 1'b1;
                     pc_q     <= pc_d;
                     issued_q <= issued_d;
                  end
               end
            end
            ST_HALT: begin
               valid_q  <= 1'b0;
               halted_q <= 1'b1;
               if (bus.start) begin
                  state_q  <= ST_RUN;
                  pc_q     <= '0;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               valid_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.r1     = fields_q.r1;
   assign bus.r2     = fields_q.r2;
   assign bus.rd     = fields_q.rd;
   assign bus.func   = fields_q.func;
   assign bus.addr   = fields_q.addr;
   assign bus.valid  = valid_q;
   assign bus.pc     = pc_q;
   assign bus.halted = halted_q;
   assign bus.issued = issued_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed programs plus random programs and stalls,
// checked against a program-level trace model of expected issue/bubble/halt events.
module tb_instr_fetch_decode;
   import ifd_pkg::*;

   localparam int PC_W  = 8;
   localparam int CNT_W = 16;
   localparam int DEPTH = 2**PC_W;

   localparam int EV_ISSUE  = 0;
   localparam int EV_BUBBLE = 1;
   localparam int EV_HALT   = 2;

   typedef struct {
      int          kind;
      int          pc_after;
      logic [23:0] w;
   } ev_t;

   logic clk1 = 1'b0;
   logic rst;

   instr_fetch_decode_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();
   instr_fetch_decode #(.PC_W(PC_W), .CNT_W(CNT_W)) myifd (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk1 = ~clk1;

   int          n_pass = 0;
   int          n_total = 0;
   int          exp_issued = 0;
   logic [23:0] mem_m [DEPTH];
   ev_t         evq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   function automatic logic [23:0] out_word();
      return {bus.func, bus.rd, bus.r1, bus.r2, bus.addr};
   endfunction

   task automatic write_mem(input int a, input logic [23:0] d);
      bus.imem_we    = 1'b1;
      bus.imem_waddr = PC_W'(a);
      bus.imem_wdata = d;
      tick();
      bus.imem_we    = 1'b0;
      mem_m[a]       = d;
   endtask

   // Walk the program as the execute pipeline should see it.
   task automatic build_model(input int max_ev);
      int pc;
      logic [23:0] w;
      ev_t e;
      pc = 0;
      evq.delete();
      while (evq.size() < max_ev) begin
         w = mem_m[pc];
         if (w[23:20] == 4'd15) begin
            e.kind = EV_HALT; e.pc_after = pc; e.w = w;
            evq.push_back(e);
            break;
         end
`ifdef BRANCH_EN
         if (w[23:20] == 4'd14) begin
            pc = int'(w[7:0]) % DEPTH;
            e.kind = EV_BUBBLE; e.pc_after = pc; e.w = w;
            evq.push_back(e);
            continue;
         end
`endif
         pc = (pc + 1) % DEPTH;
         e.kind = EV_ISSUE; e.pc_after = pc; e.w = w;
         evq.push_back(e);
      end
   endtask

   // mode 0: no stall, 1: random stall and stray start, 2: 3-cycle stall after 2nd issue
   task automatic run_program(input int mode, input int max_ev, input bit wr_run,
                              input bit wr_start, input int wa, input logic [23:0] wd,
                              output bit ended_halt);
      ev_t         e;
      bit          s;
      bit          done;
      int          cyc;
      int          n_iss;
      int          n_stall;
      logic [23:0] prev_w;
      logic [7:0]  prev_pc;
      logic        prev_v;

      if (wr_start) mem_m[wa] = wd;
      build_model(max_ev);
      bus.imem_we    = wr_start;
      bus.imem_waddr = PC_W'(wa);
      bus.imem_wdata = wd;
      bus.start      = 1'b1;
      bus.stall      = 1'b0;
      tick();
      bus.start   = 1'b0;
      bus.imem_we = wr_run;
      check("start_valid", 32'(bus.valid), 32'd0);
      check("start_pc", 32'(bus.pc), 32'd0);
      check("start_halted", 32'(bus.halted), 32'd0);

      done = 1'b0; ended_halt = 1'b0;
      cyc = 0; n_iss = 0; n_stall = 0;
      while (!done && cyc < 4 * max_ev + 50) begin
         s = 1'b0;
         if (mode == 1) begin
            s = ($urandom % 4) == 0;
            bus.start = ($urandom % 8) == 0;
         end else if (mode == 2 && n_iss == 2 && n_stall < 3) begin
            s = 1'b1;
            n_stall++;
         end
         bus.stall = s;
         prev_w  = out_word();
         prev_pc = bus.pc;
         prev_v  = bus.valid;
         tick();
         cyc++;
         if (s) begin
            check("stall_valid", 32'(bus.valid), 32'(prev_v));
            check("stall_pc", 32'(bus.pc), 32'(prev_pc));
            check("stall_fields", 32'(out_word()), 32'(prev_w));
         end else begin
            e = evq.pop_front();
            if (e.kind == EV_ISSUE) begin
               exp_issued++;
               n_iss++;
               check("issue_valid", 32'(bus.valid), 32'd1);
               check("issue_fields", 32'(out_word()), 32'(e.w));
               check("issue_pc", 32'(bus.pc), 32'(e.pc_after));
               check("issue_halted", 32'(bus.halted), 32'd0);
            end else begin
               check(e.kind == EV_HALT ? "halt_valid" : "jmp_valid", 32'(bus.valid), 32'd0);
               check(e.kind == EV_HALT ? "halt_pc" : "jmp_pc", 32'(bus.pc), 32'(e.pc_after));
               check(e.kind == EV_HALT ? "halt_fields" : "jmp_fields", 32'(out_word()), 32'(prev_w));
               check(e.kind == EV_HALT ? "halt_flag" : "jmp_flag", 32'(bus.halted),
                     e.kind == EV_HALT ? 32'd1 : 32'd0);
            end
            check("issued_cnt", 32'(bus.issued), 32'(exp_issued));
            if (e.kind == EV_HALT) ended_halt = 1'b1;
            if (evq.size() == 0) done = 1'b1;
         end
      end
      bus.start   = 1'b0;
      bus.stall   = 1'b0;
      bus.imem_we = 1'b0;
      if (!done) check("run_timeout", 32'd0, 32'd1);
   endtask

   // Reset asserted between edges must clear outputs without waiting for a clock.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_valid", 32'(bus.valid), 32'd0);
      check("rst_fields", 32'(out_word()), 32'd0);
      check("rst_issued", 32'(bus.issued), 32'd0);
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_halted", 32'(bus.halted), 32'd0);
      rst = 1'b0;
      exp_issued = 0;
      tick();
      check("post_rst_valid", 32'(bus.valid), 32'd0);
      check("post_rst_pc", 32'(bus.pc), 32'd0);
   endtask

   logic [23:0] prog1 [5];
   logic [23:0] new_w;
   logic [23:0] rw;
   bit          eh;

   initial begin
      bus.start = 1'b0; bus.stall = 1'b0; bus.imem_we = 1'b0;
      bus.imem_waddr = '0; bus.imem_wdata = '0;
      rst = 1'b1;
      #12;
      check("reset_valid", 32'(bus.valid), 32'd0);
      check("reset_pc", 32'(bus.pc), 32'd0);
      check("reset_halted", 32'(bus.halted), 32'd0);
      check("reset_issued", 32'(bus.issued), 32'd0);
      check("reset_fields", 32'(out_word()), 32'd0);
      rst = 1'b0;
      tick();

      prog1[0] = {4'd0, 4'd10, 4'd3, 4'd5, 8'd125};
      prog1[1] = {4'd1, 4'd12, 4'd7, 4'd5, 8'd127};
      prog1[2] = {4'd2, 4'd11, 4'd8, 4'd5, 8'd128};
      prog1[3] = {4'd3, 4'd13, 4'd3, 4'd5, 8'd129};
      prog1[4] = {4'd15, 20'h0};
      for (int k = 0; k < 5; k++) write_mem(k, prog1[k]);

      run_program(0, 64, 1'b0, 1'b0, 0, 24'h0, eh);
      check("p1_issued", 32'(bus.issued), 32'd4);
      check("p1_pc", 32'(bus.pc), 32'd4);

      bus.stall = 1'b1;
      tick();
      check("halt_ignores_stall", 32'(bus.halted), 32'd1);
      bus.stall = 1'b0;

      run_program(2, 64, 1'b0, 1'b0, 0, 24'h0, eh);

      new_w = {4'd5, 4'd1, 4'd2, 4'd3, 8'd44};
      run_program(0, 64, 1'b1, 1'b0, 2, new_w, eh);
      run_program(0, 64, 1'b0, 1'b1, 2, new_w, eh);

      write_mem(0, {4'd0, 4'd1, 4'd2, 4'd3, 8'd10});
      write_mem(1, {4'd14, 4'd4, 4'd5, 4'd6, 8'd6});
      for (int k = 2; k < 6; k++) write_mem(k, {4'd1, 4'(k), 4'd1, 4'd2, 8'(k)});
      write_mem(6, {4'd2, 4'd7, 4'd8, 4'd9, 8'd77});
      write_mem(7, {4'd15, 20'h0});
      run_program(1, 64, 1'b0, 1'b0, 0, 24'h0, eh);

      for (int k = 0; k < DEPTH; k++) begin
         rw = 24'($urandom);
         rw[23:20] = 4'($urandom_range(0, 13));
         write_mem(k, rw);
      end
      write_mem(DEPTH - 1, {4'd0, 4'd9, 4'd1, 4'd1, 8'd255});
      run_program(1, DEPTH + 3, 1'b0, 1'b0, 0, 24'h0, eh);
      mid_reset();

      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < DEPTH; k++) write_mem(k, 24'($urandom));
         run_program(1, 300, 1'b0, 1'b0, 0, 24'h0, eh);
         if (!eh) mid_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
